score_keeper: RTL and testbench

//  Game scoreboard fed by the playfield stage: counts distance points per frame, star bonuses and

---
 rtl/score_pkg.sv | 23 ++
 rtl/bcd_add6.sv | 41 ++++
 rtl/score_keeper.sv | 188 ++++++++++++++++++
 tb/tb_score_keeper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Purpose: shared types and helpers for the score keeper (packed BCD score, FSM states).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package score_pkg;

    // Six packed BCD digits; [0] is the least significant digit.
    typedef logic [5:0][3:0] bcd6_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam bcd6_t BCD_MAX = 24'h999999;

    // Packed BCD keeps digit significance in bit order, so a plain unsigned
    // compare of the 24-bit vectors is a numeric compare.
    function automatic logic bcd_gt(input bcd6_t a, input bcd6_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/bcd_add6.sv
// Purpose: 6-digit packed BCD + 2-digit BCD addend, saturating at 999999.
// Latency: combinational.
// Backpressure: none; result valid whenever inputs are stable.
// Ports: a_i score operand, b_i 2-digit BCD addend {tens,ones},
//        sum_o saturated sum, sat_o high when the true sum exceeded 999999.
module bcd_add6
    import score_pkg::*;
(
    input  bcd6_t      a_i,
    input  logic [7:0] b_i,
    output bcd6_t      sum_o,
    output logic       sat_o
);

    bcd6_t      raw;
    logic [4:0] dsum;
    logic [3:0] bdig;
    logic       carry;

    // Ripple digit by digit; a digit sum never exceeds 9+9+1 = 19.
    always_comb begin
        raw   = '0;
        dsum  = '0;
        bdig  = '0;
        carry = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bdig = (i == 0) ? b_i[3:0] : ((i == 1) ? b_i[7:4] : 4'd0);
            dsum = {1'b0, a_i[i]} + {1'b0, bdig} + {4'd0, carry};
            if (dsum > 5'd9) begin
                raw[i] = 4'(dsum - 5'd10);
                carry  = 1'b1;
            end else begin
                raw[i] = dsum[3:0];
                carry  = 1'b0;
            end
        end
        sat_o = carry;
        sum_o = carry ? BCD_MAX : raw;
    end

endmodule

// File: rtl/score_keeper.sv
// Purpose: game scoreboard: distance points per frame, star bonus, nitro doubling, session high score.
// Latency: score updates 1 cycle after the synchronised event pulse; display 1 cycle after that.
// Backpressure: none; event pulses are consumed in the cycle they occur.
// Ports: Clk, Reset_n (async active-low); vs, collect, replay asynchronous, 2-flop synchronised;
//        start, nosActive, show_high levels; hex_num 6 BCD digits, hex_blank leading-zero mask,
//        game_over high while the final score is frozen.
module score_keeper
    import score_pkg::*;
#(
    parameter int FRAMES_PER_PT = 6,
    parameter int STAR_PTS      = 25,
    parameter int HOLD_FRAMES   = 180
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic       start,
    input  logic       collect,
    input  logic       nosActive,
    input  logic       replay,
    input  logic       show_high,
    output bcd6_t      hex_num,
    output logic [5:0] hex_blank,
    output logic       game_over
);

    localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_PT - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] STAR_TENS  = 4'(STAR_PTS / 10);
    localparam logic [3:0] STAR_ONES  = 4'(STAR_PTS % 10);

    logic [1:0] vs_sync_q, col_sync_q, rep_sync_q;
    logic       vs_prev_q, col_prev_q, rep_prev_q;
    logic       frame_tick, collect_rise, replay_rise;

    state_t     state_q, state_d;
    bcd6_t      score_q, score_d, high_q, high_d;
    logic [5:0] frame_q, frame_d;
    logic [7:0] hold_q, hold_d;

    logic       dist_pt;
    logic [1:0] dist_val;
    logic [3:0] star_tens, star_ones, add_tens, add_ones;
    logic [4:0] ones_sum;
    logic [7:0] addend;
    bcd6_t      add_sum;
    logic       add_sat;

    bcd6_t      disp;
    logic [5:0] blank;
    bcd6_t      hex_num_q;
    logic [5:0] hex_blank_q;

    // Synchronisers and edge history. vs idles high, so its history resets to 1
    // to avoid a spurious frame tick straight out of reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_sync_q  <= 2'b11;
            col_sync_q <= 2'b00;
            rep_sync_q <= 2'b00;
            vs_prev_q  <= 1'b1;
            col_prev_q <= 1'b0;
            rep_prev_q <= 1'b0;
        end else begin
            vs_sync_q  <= {vs_sync_q[0], vs};
            col_sync_q <= {col_sync_q[0], collect};
            rep_sync_q <= {rep_sync_q[0], replay};
            vs_prev_q  <= vs_sync_q[1];
            col_prev_q <= col_sync_q[1];
            rep_prev_q <= rep_sync_q[1];
        end
    end

    assign frame_tick   = vs_prev_q & ~vs_sync_q[1];
    assign collect_rise = ~col_prev_q & col_sync_q[1];
    assign replay_rise  = ~rep_prev_q & rep_sync_q[1];

    // Addend = distance (0..2) + star bonus as one 2-digit BCD value, so a
    // coincident point and star are applied in a single add. The tens digit
    // cannot overflow because the star bonus is at most 97.
    always_comb begin
        dist_pt   = frame_tick && (frame_q == FRAME_LAST);
        dist_val  = dist_pt ? (nosActive ? 2'd2 : 2'd1) : 2'd0;
        star_tens = collect_rise ? STAR_TENS : 4'd0;
        star_ones = collect_rise ? STAR_ONES : 4'd0;
        ones_sum  = {1'b0, star_ones} + {3'b0, dist_val};
        if (ones_sum > 5'd9) begin
            add_ones = 4'(ones_sum - 5'd10);
            add_tens = star_tens + 4'd1;
        end else begin
            add_ones = ones_sum[3:0];
            add_tens = star_tens;
        end
        addend = {add_tens, add_ones};
    end

    bcd_add6 u_add (
        .a_i   (score_q),
        .b_i   (addend),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    score_d = '0;
                    frame_d = '0;
                end
            end
            RUN: begin
                // Game over wins over everything; the add of that cycle is dropped.
                if (replay_rise) begin
                    state_d = FREEZE;
                    hold_d  = '0;
                    high_d  = bcd_gt(score_q, high_q) ? score_q : high_q;
                end else if (!start) begin
                    state_d = IDLE;
                end else begin
                    if (frame_tick) begin
                        frame_d = dist_pt ? 6'd0 : frame_q + 6'd1;
                    end
                    score_d = add_sat ? BCD_MAX : add_sum;
                end
            end
            FREEZE: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            score_q <= '0;
            high_q  <= '0;
            frame_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
        end
    end

    // Digit i is blank only when it and every more significant digit are zero;
    // digit 0 always shows.
    always_comb begin
        disp     = show_high ? high_q : score_q;
        blank    = '0;
        blank[5] = (disp[5] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            blank[i] = blank[i+1] && (disp[i] == 4'd0);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hex_num_q   <= '0;
            hex_blank_q <= 6'b111110;
        end else begin
            hex_num_q   <= disp;
            hex_blank_q <= blank;
        end
    end

    assign hex_num   = hex_num_q;
    assign hex_blank = hex_blank_q;
    assign game_over = (state_q == FREEZE);

endmodule

// File: tb/tb_score_keeper.sv
// Purpose: directed self-checking bench for score_keeper with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_score_keeper;
    import score_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n, vs, start, collect, nosActive, replay, show_high;
    logic [5:0][3:0] hex_num;
    logic [5:0]  hex_blank;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .vs        (vs),
        .start     (start),
        .collect   (collect),
        .nosActive (nosActive),
        .replay    (replay),
        .show_high (show_high),
        .hex_num   (hex_num),
        .hex_blank (hex_blank),
        .game_over (game_over)
    );

    always #5 Clk = ~Clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame: vs low for 2 cycles then high for 2 cycles.
    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            @(negedge Clk); vs = 1'b0;
            cycles(2);
            vs = 1'b1;
            cycles(1);
        end
        cycles(1);
    endtask

    task automatic collect_pulse(input int n);
        @(negedge Clk); collect = 1'b1;
        cycles(n);
        collect = 1'b0;
        cycles(4);
    endtask

    task automatic preload(input logic [23:0] s, input logic [23:0] h);
        @(negedge Clk);
        force dut.score_q = s;
        force dut.high_q  = h;
        @(negedge Clk);
        release dut.score_q;
        release dut.high_q;
        cycles(2);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; vs = 1'b1; start = 1'b0; collect = 1'b0;
        nosActive = 1'b0; replay = 1'b0; show_high = 1'b0;
        cycles(3);
        checks++; if (hex_num !== 24'h000000) begin errors++; $display("FAIL por_hex got %h want 000000", hex_num); end
        checks++; if (hex_blank !== 6'b111110) begin errors++; $display("FAIL por_blank got %b want 111110", hex_blank); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL por_game_over got %b want 0", game_over); end
        Reset_n = 1'b1; start = 1'b1;
        cycles(3);
        preload(24'h000042, 24'h000090);
        checks++; if (hex_num !== 24'h000042) begin errors++; $display("FAIL pre_score got %h want 000042", hex_num); end
        show_high = 1'b1; cycles(2);
        checks++; if (hex_num !== 24'h000090) begin errors++; $display("FAIL pre_high got %h want 000090", hex_num); end
        // Asynchronous reset in the middle of a cycle, checked before any clock edge.
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (hex_num !== 24'h000000) begin errors++; $display("FAIL rst_hex got %h want 000000", hex_num); end
        checks++; if (hex_blank !== 6'b111110) begin errors++; $display("FAIL rst_blank got %b want 111110", hex_blank); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_game_over got %b want 0", game_over); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dut.state_q); end
        show_high = 1'b0;
        cycles(2);
        Reset_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_distance;
        frames(60);
        cycles(2);
        checks++; if (hex_num !== 24'h000010) begin errors++; $display("FAIL dist60 got %h want 000010", hex_num); end
        checks++; if (hex_blank !== 6'b111100) begin errors++; $display("FAIL dist60_blank got %b want 111100", hex_blank); end
        frames(5);
        cycles(2);
        checks++; if (hex_num !== 24'h000010) begin errors++; $display("FAIL dist_partial got %h want 000010", hex_num); end
        frames(1);
        cycles(2);
        checks++; if (hex_num !== 24'h000011) begin errors++; $display("FAIL dist_wrap got %h want 000011", hex_num); end
    endtask

    task automatic test_nitro;
        nosActive = 1'b1;
        frames(12);
        cycles(2);
        checks++; if (hex_num !== 24'h000015) begin errors++; $display("FAIL nitro got %h want 000015", hex_num); end
        // Five more frames park the frame counter one tick before a point.
        frames(5);
        @(negedge Clk); vs = 1'b0; collect = 1'b1;
        cycles(2);
        vs = 1'b1;
        cycles(3);
        collect = 1'b0;
        cycles(4);
        checks++; if (hex_num !== 24'h000042) begin errors++; $display("FAIL star_plus_point got %h want 000042", hex_num); end
        nosActive = 1'b0;
    endtask

    task automatic test_saturate;
        preload(24'h999990, 24'h000000);
        checks++; if (hex_num !== 24'h999990) begin errors++; $display("FAIL sat_preload got %h want 999990", hex_num); end
        checks++; if (hex_blank !== 6'b000000) begin errors++; $display("FAIL sat_blank got %b want 000000", hex_blank); end
        collect_pulse(2);
        checks++; if (hex_num !== 24'h999999) begin errors++; $display("FAIL sat_add got %h want 999999", hex_num); end
        collect_pulse(2);
        checks++; if (hex_num !== 24'h999999) begin errors++; $display("FAIL sat_hold got %h want 999999", hex_num); end
    endtask

    task automatic test_freeze;
        preload(24'h000120, 24'h000080);
        @(negedge Clk); replay = 1'b1;
        cycles(5);
        replay = 1'b0;
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL frz_game_over got %b want 1", game_over); end
        show_high = 1'b1; cycles(2);
        checks++; if (hex_num !== 24'h000120) begin errors++; $display("FAIL frz_high got %h want 000120", hex_num); end
        checks++; if (hex_blank !== 6'b111000) begin errors++; $display("FAIL frz_high_blank got %b want 111000", hex_blank); end
        show_high = 1'b0;
        collect_pulse(3);
        checks++; if (hex_num !== 24'h000120) begin errors++; $display("FAIL frz_collect got %h want 000120", hex_num); end
        frames(179);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL frz_179 got %b want 1", game_over); end
        frames(1);
        cycles(2);
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL frz_180 got %b want 0", game_over); end
        checks++; if (hex_num !== 24'h000000) begin errors++; $display("FAIL restart_score got %h want 000000", hex_num); end
        show_high = 1'b1; cycles(2);
        checks++; if (hex_num !== 24'h000120) begin errors++; $display("FAIL restart_high got %h want 000120", hex_num); end
        checks++; if (hex_blank !== 6'b111000) begin errors++; $display("FAIL restart_blank got %b want 111000", hex_blank); end
        show_high = 1'b0; cycles(2);
    endtask

    task automatic test_back_to_back;
        preload(24'h000050, 24'h000120);
        checks++; if (hex_num !== 24'h000050) begin errors++; $display("FAIL b2b_preload got %h want 000050", hex_num); end
        @(negedge Clk); replay = 1'b1; collect = 1'b1;
        cycles(5);
        replay = 1'b0; collect = 1'b0;
        cycles(2);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL b2b_game_over got %b want 1", game_over); end
        checks++; if (hex_num !== 24'h000050) begin errors++; $display("FAIL b2b_score got %h want 000050", hex_num); end
        show_high = 1'b1; cycles(2);
        checks++; if (hex_num !== 24'h000120) begin errors++; $display("FAIL b2b_high got %h want 000120", hex_num); end
        show_high = 1'b0;
    endtask

    task automatic test_stop;
        frames(180);
        cycles(2);
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL stop_exit got %b want 0", game_over); end
        collect_pulse(2);
        checks++; if (hex_num !== 24'h000025) begin errors++; $display("FAIL stop_star got %h want 000025", hex_num); end
        start = 1'b0;
        cycles(2);
        frames(6);
        cycles(2);
        checks++; if (hex_num !== 24'h000025) begin errors++; $display("FAIL stop_kept got %h want 000025", hex_num); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL stop_state got %0d want IDLE", dut.state_q); end
        show_high = 1'b1; cycles(2);
        checks++; if (hex_num !== 24'h000120) begin errors++; $display("FAIL stop_high got %h want 000120", hex_num); end
        show_high = 1'b0;
        start = 1'b1;
        cycles(3);
        checks++; if (hex_num !== 24'h000000) begin errors++; $display("FAIL stop_restart got %h want 000000", hex_num); end
    endtask

    initial begin
        test_reset;
        test_distance;
        test_nitro;
        test_saturate;
        test_freeze;
        test_back_to_back;
        test_stop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
